// File: rtl/ec2_run_pkg.sv
// ec2_run_pkg: state encoding shared by the ec2 run controller files
package ec2_run_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {S_IDLE, S_RST, S_RUN, S_DONE, S_TOUT} state_e;
endpackage

// File: rtl/ec2_res_fifo.sv
// ec2_res_fifo: synchronous result FIFO with flush; a push into a full FIFO
// succeeds only when a pop frees a slot in the same cycle, otherwise o_drop.
module ec2_res_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr, r_rd;
    logic              w_empty, w_full, w_pop, w_push;

    assign w_empty = r_wr == r_rd;
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && !w_push;
    assign o_valid = !w_empty;
    assign o_data  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
endmodule

// File: rtl/ec2_run_ctrl.sv
// ec2_run_ctrl: ec2 CPU run controller (reset sequencing, input table, result FIFO).
// Define RUN_TIMEOUT_EN to enable the RUN->TOUT cycle-limit path.
module ec2_run_ctrl
    import ec2_run_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_IN     = 4,
    parameter int OUT_DEPTH  = 8,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 150,
    parameter int CNT_W      = 16
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic                      Ld_Valid,
    input  logic [$clog2(NUM_IN)-1:0] Ld_Idx,
    input  logic [DATA_W-1:0]         Ld_Data,
    output logic                      Cpu_Reset,
    output logic [DATA_W-1:0]         Cpu_Input,
    input  logic                      Cpu_In_Rd,
    input  logic [DATA_W-1:0]         Cpu_Output,
    input  logic                      Cpu_Out_Wr,
    input  logic                      Cpu_Halt,
    output logic [DATA_W-1:0]         Res_Data,
    output logic                      Res_Valid,
    input  logic                      Res_Rd,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Timeout,
    output logic                      Overflow,
    output logic [CNT_W-1:0]          Cycles
);
    localparam int PW  = $clog2(NUM_IN);
    localparam int RCW = $clog2(RST_CYCLES + 1);
`ifdef RUN_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    state_e            r_state;
    logic [RCW-1:0]    r_rst_cnt;
    logic [PW-1:0]     r_ptr;
    logic [CNT_W-1:0]  r_cycles;
    logic [DATA_W-1:0] r_table [NUM_IN];
    logic              r_cpu_reset, r_busy, r_done, r_tout, r_ovf;
    logic              w_start, w_run, w_tmo, w_drop;
    logic [CNT_W-1:0]  w_cyc_next;

    assign w_run      = r_state == S_RUN;
    assign w_start    = Start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_TOUT);
    assign w_cyc_next = (&r_cycles) ? r_cycles : r_cycles + 1'b1;
    assign w_tmo      = TMO_EN && w_run && (w_cyc_next == CNT_W'(TIMEOUT));

    assign Cpu_Reset = r_cpu_reset;
    assign Cpu_Input = r_table[r_ptr];
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Timeout   = r_tout;
    assign Overflow  = r_ovf;
    assign Cycles    = r_cycles;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_rst_cnt   <= '0;
            r_ptr       <= '0;
            r_cycles    <= '0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_tout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_start) begin
            r_state     <= S_RST;
            r_rst_cnt   <= '0;
            r_ptr       <= '0;
            r_cycles    <= '0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_tout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (r_state == S_RST) begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
            if (r_rst_cnt == RCW'(RST_CYCLES - 1)) begin
                r_state     <= S_RUN;
                r_cpu_reset <= 1'b0;
            end
        end else if (w_run) begin
            r_cycles <= w_cyc_next;
            if (Cpu_In_Rd && r_ptr != PW'(NUM_IN - 1)) r_ptr <= r_ptr + 1'b1;
            if (w_drop) r_ovf <= 1'b1;
            // halt has priority over a coincident timeout
            if (Cpu_Halt) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end else if (w_tmo) begin
                r_state <= S_TOUT;
                r_busy  <= 1'b0;
                r_tout  <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NUM_IN; i++) r_table[i] <= '0;
        end else if (Ld_Valid && !r_busy && int'(Ld_Idx) < NUM_IN) begin
            r_table[Ld_Idx] <= Ld_Data;
        end
    end

    ec2_res_fifo #(.DATA_W(DATA_W), .DEPTH(OUT_DEPTH)) u_fifo (
        .clk     (Clock),
        .rst     (Reset),
        .i_flush (w_start),
        .i_push  (w_run && Cpu_Out_Wr),
        .i_data  (Cpu_Output),
        .i_pop   (Res_Rd),
        .o_data  (Res_Data),
        .o_valid (Res_Valid),
        .o_drop  (w_drop)
    );
endmodule

// File: tb/tb_ec2_run_ctrl.sv
// tb_ec2_run_ctrl: self-checking bench for ec2_run_ctrl with a result-FIFO scoreboard.
// Honours RUN_TIMEOUT_EN to select the timeout expectations.
module tb_ec2_run_ctrl;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Ld_Valid = 1'b0;
    logic [1:0]  Ld_Idx = '0;
    logic [15:0] Ld_Data = '0;
    logic        Cpu_Reset;
    logic [15:0] Cpu_Input;
    logic        Cpu_In_Rd = 1'b0;
    logic [15:0] Cpu_Output = '0;
    logic        Cpu_Out_Wr = 1'b0;
    logic        Cpu_Halt = 1'b0;
    logic [15:0] Res_Data;
    logic        Res_Valid;
    logic        Res_Rd = 1'b0;
    logic        Busy, Done, Timeout, Overflow;
    logic [15:0] Cycles;

    int          n_chk = 0;
    int          n_fail = 0;
    int          run_cyc = 0;
    logic [15:0] exp_q[$];
    logic        exp_ovf = 1'b0;

    ec2_run_ctrl dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Ld_Valid(Ld_Valid), .Ld_Idx(Ld_Idx),
        .Ld_Data(Ld_Data), .Cpu_Reset(Cpu_Reset), .Cpu_Input(Cpu_Input), .Cpu_In_Rd(Cpu_In_Rd),
        .Cpu_Output(Cpu_Output), .Cpu_Out_Wr(Cpu_Out_Wr), .Cpu_Halt(Cpu_Halt),
        .Res_Data(Res_Data), .Res_Valid(Res_Valid), .Res_Rd(Res_Rd), .Busy(Busy),
        .Done(Done), .Timeout(Timeout), .Overflow(Overflow), .Cycles(Cycles)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic run_tick();
        tick();
        run_cyc++;
    endtask

    task automatic start_run();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (Cpu_Reset === 1'b1 && n < 10) begin
            tick();
            n++;
        end
        run_cyc = 0;
        if (n >= 10) begin
            n_chk++; n_fail++;
            $display("FAIL wait_run: Cpu_Reset still %b after %0d cycles, required 0", Cpu_Reset, n);
        end
    endtask

    task automatic push_out(input logic [15:0] d, input logic rd);
        Cpu_Out_Wr = 1'b1;
        Cpu_Output = d;
        Res_Rd = rd;
        if (rd && exp_q.size() > 0) begin
            n_chk++;
            if (Res_Data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL pop_on_push: Res_Data=%h required %h", Res_Data, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        if (exp_q.size() < 8) exp_q.push_back(d);
        else exp_ovf = 1'b1;
        run_tick();
        Cpu_Out_Wr = 1'b0;
        Res_Rd = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            n_chk++;
            if (Res_Valid !== 1'b1 || Res_Data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL drain: Res_Valid=%b Res_Data=%h required 1 %h", Res_Valid, Res_Data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            Res_Rd = 1'b1;
            tick();
            Res_Rd = 1'b0;
            n++;
        end
        n_chk++;
        if (Res_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: Res_Valid=%b required 0", Res_Valid);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        n_chk++;
        if ({Cpu_Reset, Busy, Done, Timeout, Overflow, Res_Valid} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: Cpu_Reset,Busy,Done,Timeout,Overflow,Res_Valid=%b required 100000",
                     {Cpu_Reset, Busy, Done, Timeout, Overflow, Res_Valid});
        end
        n_chk++;
        if (Cycles !== 16'd0 || Cpu_Input !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: Cycles=%0d Cpu_Input=%0d required 0 0", Cycles, Cpu_Input);
        end
    endtask

    task automatic test_load_start();
        logic [15:0] tbl[4] = '{16'd31, 16'd7, 16'd9, 16'd2};
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            Ld_Valid = 1'b1; Ld_Idx = 2'(i); Ld_Data = tbl[i];
            tick();
        end
        Ld_Valid = 1'b0;
        start_run();
        while (Cpu_Reset === 1'b1 && n < 10) begin
            n++;
            tick();
        end
        run_cyc = 0;
        n_chk++;
        if (n !== 2) begin
            n_fail++;
            $display("FAIL rst_len: Cpu_Reset high %0d cycles required 2", n);
        end
        n_chk++;
        if (Cpu_Input !== 16'd31 || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_input: Cpu_Input=%0d Busy=%b required 31 1", Cpu_Input, Busy);
        end
        Ld_Valid = 1'b1; Ld_Idx = 2'd0; Ld_Data = 16'd99;
        run_tick();
        Ld_Valid = 1'b0;
        n_chk++;
        if (Cpu_Input !== 16'd31) begin
            n_fail++;
            $display("FAIL load_busy: Cpu_Input=%0d required 31", Cpu_Input);
        end
    endtask

    task automatic test_feed();
        logic [15:0] exp[4] = '{16'd7, 16'd9, 16'd2, 16'd2};
        for (int i = 0; i < 4; i++) begin
            Cpu_In_Rd = 1'b1;
            run_tick();
            Cpu_In_Rd = 1'b0;
            n_chk++;
            if (Cpu_Input !== exp[i]) begin
                n_fail++;
                $display("FAIL feed%0d: Cpu_Input=%0d required %0d", i, Cpu_Input, exp[i]);
            end
        end
    endtask

    task automatic test_halt();
        push_out(16'h0011, 1'b0);
        push_out(16'h0022, 1'b0);
        n_chk++;
        if (Cycles !== 16'(run_cyc)) begin
            n_fail++;
            $display("FAIL cycles_mid: Cycles=%0d required %0d", Cycles, run_cyc);
        end
        while (run_cyc < 10) run_tick();
        Start = 1'b1;
        run_tick();
        Start = 1'b0;
        n_chk++;
        if (Cpu_Reset !== 1'b0 || Cycles !== 16'd11) begin
            n_fail++;
            $display("FAIL start_in_run: Cpu_Reset=%b Cycles=%0d required 0 11", Cpu_Reset, Cycles);
        end
        while (run_cyc < 19) run_tick();
        Cpu_Halt = 1'b1;
        push_out(16'h0033, 1'b0);
        Cpu_Halt = 1'b0;
        n_chk++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Cycles !== 16'd20 || Cpu_Reset !== 1'b0) begin
            n_fail++;
            $display("FAIL halt: Done=%b Busy=%b Cycles=%0d Cpu_Reset=%b required 1 0 20 0",
                     Done, Busy, Cycles, Cpu_Reset);
        end
        drain();
        n_chk++;
        if (Cycles !== 16'd20) begin
            n_fail++;
            $display("FAIL cycles_frozen: Cycles=%0d required 20", Cycles);
        end
    endtask

    task automatic test_overflow();
        start_run();
        wait_run();
        for (int i = 0; i < 9; i++) push_out(16'(256 + i), 1'b0);
        n_chk++;
        if (Overflow !== exp_ovf || Res_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: Overflow=%b Res_Valid=%b required %b 1", Overflow, Res_Valid, exp_ovf);
        end
        push_out(16'h0200, 1'b1);
        drain();
        push_out(16'h0300, 1'b1);
        n_chk++;
        if (Res_Valid !== 1'b1 || Res_Data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL empty_push_pop: Res_Valid=%b Res_Data=%h required 1 %h", Res_Valid, Res_Data, exp_q[0]);
        end
        push_out(16'h0301, 1'b0);
        Cpu_Halt = 1'b1;
        run_tick();
        Cpu_Halt = 1'b0;
        start_run();
        exp_q.delete();
        exp_ovf = 1'b0;
        n_chk++;
        if (Res_Valid !== 1'b0 || Overflow !== exp_ovf || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush: Res_Valid=%b Overflow=%b Busy=%b required 0 0 1", Res_Valid, Overflow, Busy);
        end
        wait_run();
    endtask

    task automatic test_timeout();
`ifdef RUN_TIMEOUT_EN
        while (Busy === 1'b1 && run_cyc < 400) run_tick();
        n_chk++;
        if (Timeout !== 1'b1 || Done !== 1'b0 || Cycles !== 16'd150 || run_cyc !== 150) begin
            n_fail++;
            $display("FAIL timeout: Timeout=%b Done=%b Cycles=%0d after %0d cycles required 1 0 150 150",
                     Timeout, Done, Cycles, run_cyc);
        end
`else
        while (run_cyc < 300) run_tick();
        n_chk++;
        if (Busy !== 1'b1 || Timeout !== 1'b0 || Cycles !== 16'd300) begin
            n_fail++;
            $display("FAIL no_timeout: Busy=%b Timeout=%b Cycles=%0d required 1 0 300", Busy, Timeout, Cycles);
        end
`endif
    endtask

    task automatic test_reset_mid_run();
        if (Busy !== 1'b1) begin
            start_run();
            wait_run();
        end
        push_out(16'h0444, 1'b0);
        run_tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        exp_q.delete();
        n_chk++;
        if (Busy !== 1'b0 || Cpu_Reset !== 1'b1 || Res_Valid !== 1'b0 || Cycles !== 16'd0 || Cpu_Input !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: Busy=%b Cpu_Reset=%b Res_Valid=%b Cycles=%0d Cpu_Input=%0d required 0 1 0 0 0",
                     Busy, Cpu_Reset, Res_Valid, Cycles, Cpu_Input);
        end
    endtask

    initial begin
        test_reset();
        test_load_start();
        test_feed();
        test_halt();
        test_overflow();
        test_timeout();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
